// File: rtl/izh_synapse.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | izh_synapse: spike edge -> weighted, decaying, saturated Q9.7 current |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module izh_synapse #(
  parameter int DECAY_SHIFT    = 3,
  parameter int DECAY_PERIOD   = 4,
  parameter int REFRACT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               clear,
  input  logic               spike_in,
  input  logic signed [15:0] weight,
  input  logic signed [15:0] bias,
  output logic signed [15:0] current,
  output logic               event_pulse,
  output logic [7:0]         spike_count
);

  localparam logic [7:0] c_dcnt_last = 8'(DECAY_PERIOD - 1);
  localparam logic [3:0] c_refract   = 4'(REFRACT_CYCLES);

  logic signed [15:0] r_syn;
  logic signed [15:0] r_current;
  logic               r_event;
  logic [7:0]         r_spike_count;
  logic [3:0]         r_refr;
  logic [7:0]         r_dcnt;
  logic               r_spike_q;

  logic               w_tick;
  logic               w_edge;
  logic               w_accept;
  logic signed [15:0] w_dec_amt;
  logic signed [15:0] w_decayed;
  logic signed [16:0] w_sum;
  logic signed [15:0] w_syn_next;
  logic signed [15:0] w_cur_next;

  function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
    if (v[16] != v[15]) return v[16] ? 16'sh8000 : 16'sh7fff;
    return v[15:0];
  endfunction

  assign w_tick    = (r_dcnt == c_dcnt_last);
  assign w_edge    = spike_in & ~r_spike_q & enable;
  assign w_accept  = w_edge & (r_refr == 4'd0);
  assign w_dec_amt = r_syn >>> DECAY_SHIFT;

  // Small magnitudes shift to zero decrement; force one LSB toward zero so syn always settles.
  always_comb begin
    w_decayed = r_syn;
    if (w_tick) begin
      if (r_syn != 16'sd0 && w_dec_amt == 16'sd0)
        w_decayed = (r_syn > 16'sd0) ? r_syn - 16'sd1 : r_syn + 16'sd1;
      else
        w_decayed = r_syn - w_dec_amt;
    end
  end

  assign w_sum      = {w_decayed[15], w_decayed} + (w_accept ? {weight[15], weight} : 17'sd0);
  assign w_syn_next = sat16(w_sum);
  assign w_cur_next = sat16({w_syn_next[15], w_syn_next} + {bias[15], bias});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_syn         <= '0;
      r_current     <= '0;
      r_event       <= 1'b0;
      r_spike_count <= '0;
      r_refr        <= '0;
      r_dcnt        <= '0;
      r_spike_q     <= 1'b0;
    end else if (clear) begin
      r_syn         <= '0;
      r_current     <= bias;
      r_event       <= 1'b0;
      r_spike_count <= '0;
      r_refr        <= '0;
      r_dcnt        <= '0;
      r_spike_q     <= spike_in;
    end else if (enable) begin
      r_spike_q <= spike_in;
      r_syn     <= w_syn_next;
      r_current <= w_cur_next;
      r_event   <= w_accept;
      r_dcnt    <= w_tick ? 8'd0 : r_dcnt + 8'd1;
      if (w_accept) begin
        r_refr <= c_refract;
        if (r_spike_count != 8'hff) r_spike_count <= r_spike_count + 8'd1;
      end else if (r_refr != 4'd0) begin
        r_refr <= r_refr - 4'd1;
      end
    end else begin
      r_event <= 1'b0;
    end
  end

  assign current     = r_current;
  assign event_pulse = r_event;
  assign spike_count = r_spike_count;

endmodule
`default_nettype wire

// File: tb/tb_izh_synapse.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_izh_synapse: directed and random checks against a behavioural model |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_izh_synapse;
  localparam int DS = 3;
  localparam int DP = 4;
  localparam int RC = 2;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               enable = 1'b1;
  logic               clear = 1'b0;
  logic               spike_in = 1'b0;
  logic signed [15:0] weight = '0;
  logic signed [15:0] bias = '0;
  logic signed [15:0] current;
  logic               event_pulse;
  logic [7:0]         spike_count;

  int total = 0;
  int bad = 0;

  // behavioural state
  int m_syn, m_cur, m_cnt, m_refr, m_phase;
  bit m_q, m_ev;

  izh_synapse #(.DECAY_SHIFT(DS), .DECAY_PERIOD(DP), .REFRACT_CYCLES(RC)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
    .spike_in(spike_in), .weight(weight), .bias(bias),
    .current(current), .event_pulse(event_pulse), .spike_count(spike_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clamp(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int floor_div(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  function automatic int s16(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  task automatic model_reset();
    m_syn = 0; m_cur = 0; m_cnt = 0; m_refr = 0; m_phase = 0; m_q = 0; m_ev = 0;
  endtask

  // One rising edge of the reference: decay on every DP-th enabled cycle, then add weight.
  task automatic model_clock();
    bit acc;
    int dec;
    if (clear) begin
      m_syn = 0; m_refr = 0; m_phase = 0; m_cnt = 0; m_ev = 0;
      m_q = spike_in; m_cur = int'(bias);
    end else if (enable) begin
      acc = spike_in && !m_q && (m_refr == 0);
      dec = m_syn;
      if (m_phase == DP - 1) begin
        dec = m_syn - floor_div(m_syn, 1 << DS);
        if (dec == m_syn && m_syn != 0) dec = m_syn + ((m_syn > 0) ? -1 : 1);
      end
      m_syn = clamp(dec + (acc ? int'(weight) : 0));
      m_cur = clamp(m_syn + int'(bias));
      m_ev = acc;
      m_phase = (m_phase + 1) % DP;
      if (acc) begin
        m_refr = RC;
        if (m_cnt < 255) m_cnt++;
      end else if (m_refr > 0) begin
        m_refr--;
      end
      m_q = spike_in;
    end else begin
      m_ev = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (reset_n) model_clock();
    #1;
    chk("current", int'(current), m_cur);
    chk("event", int'(event_pulse), int'(m_ev));
    chk("count", int'(spike_count), m_cnt);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_clear();
    clear = 1'b1; step(); clear = 1'b0;
  endtask

  task automatic pattern(input int n, input logic [15:0] bits);
    for (int i = 0; i < n; i++) begin
      spike_in = bits[n-1-i];
      step();
    end
  endtask

  initial begin
    model_reset();
    // reset held with active stimulus
    bias = 16'sh0100; weight = 16'sh1234;
    for (int i = 0; i < 3; i++) begin
      spike_in = ~spike_in;
      @(posedge clk); #1;
    end
    chk("rst_cur", s16(current), 0);
    chk("rst_ev", int'(event_pulse), 0);
    chk("rst_cnt", int'(spike_count), 0);
    spike_in = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    step();
    chk("rel_cur", s16(current), s16(16'h0100));

    // single spike and decay
    bias = 0; weight = 16'sh0280;
    do_clear();
    spike_in = 1'b1; step();
    chk("single_cur", s16(current), s16(16'h0280));
    chk("single_ev", int'(event_pulse), 1);
    spike_in = 1'b0; steps(3);
    chk("decay1", s16(current), s16(16'h0230));
    steps(4);

    // held level -> one event
    do_clear();
    spike_in = 1'b1; steps(10); spike_in = 1'b0; step();
    chk("held_cnt", int'(spike_count), 1);

    // refractory spacing 2 then 3
    do_clear();
    pattern(6, 16'b101000);
    chk("refr2_cnt", int'(spike_count), 1);
    do_clear();
    pattern(5, 16'b10010);
    chk("refr3_cnt", int'(spike_count), 2);

    // saturation
    do_clear(); weight = 16'sh7000;
    pattern(4, 16'b1001);
    chk("sat_pos", s16(current), s16(16'h7fff));
    spike_in = 0; step();
    do_clear(); weight = 16'sh9000;
    pattern(4, 16'b1001);
    chk("sat_neg", s16(current), s16(16'h8000));
    spike_in = 0; step();
    bias = 16'sh7f00; do_clear(); weight = 16'sh0200;
    spike_in = 1; step();
    chk("sat_bias", s16(current), s16(16'h7fff));
    spike_in = 0; bias = 0; step();

    // decay to zero, both signs
    do_clear(); weight = 16'sh0007;
    spike_in = 1; step(); spike_in = 0; steps(30);
    chk("dz_pos", s16(current), 0);
    do_clear(); weight = -16'sd7;
    spike_in = 1; step(); spike_in = 0; steps(30);
    chk("dz_neg", s16(current), 0);

    // edge on a decay tick
    do_clear(); weight = 16'sh0100;
    pattern(3, 16'b100);
    weight = 16'sh0080; spike_in = 1; step();
    chk("coinc", s16(current), s16(16'h0160));
    spike_in = 0; steps(2);

    // clear with coincident edge
    bias = 16'sh0040; clear = 1; spike_in = 1; step();
    chk("clr_ev", int'(event_pulse), 0);
    chk("clr_cur", s16(current), s16(16'h0040));
    clear = 0; step();
    chk("clr_noedge", int'(event_pulse), 0);
    spike_in = 0; step();

    // disabled edge seen when re-enabled
    enable = 0; spike_in = 1; steps(3);
    enable = 1; step();
    chk("en_ev", int'(event_pulse), 1);
    spike_in = 0; step();

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      enable   = ($urandom_range(0, 9) != 0);
      clear    = ($urandom_range(0, 39) == 0);
      spike_in = $urandom_range(0, 1);
      weight   = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($signed($urandom_range(0, 64)) - 32);
      bias     = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'sd0;
      step();
    end
    enable = 1; clear = 0;

    // async reset between clock edges
    weight = 16'sh0500; spike_in = 0; step(); spike_in = 1; step();
    #2 reset_n = 1'b0;
    #1;
    chk("async_cur", s16(current), 0);
    chk("async_cnt", int'(spike_count), 0);
    model_reset();
    @(negedge clk); reset_n = 1'b1; spike_in = 0;
    steps(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
